fp_subtractor_seq: RTL and testbench

Multi-cycle IEEE-754 single-precision subtractor computing `out = src0 - src1`. It is the inverse-operation companion to the combinational floating-point adder in the datapath library. Both blocks use the same simplified number model: implicit leading one, truncation, no NaN/Inf/denormal handling. This block trades latency for area: alignment and normalization use a 1-bit-per-cycle shifter behind valid/ready handshakes, so it drops into pipelines where stalls are legal.

---
 rtl/fp_subtractor_seq.sv | 130 +++++++++++++
 tb/tb_fp_subtractor_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fp_subtractor_seq.sv
// Multi-cycle binary32 subtractor (out = src0 - src1) using a simplified float model:
// implicit one, truncation, no NaN/Inf/denormals. Alignment and normalisation shift one bit per cycle.
module fp_subtractor_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] src0,
    input  logic [31:0] src1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, ALIGN, OPER, NORM, DONE} state_t;

    state_t      state;
    logic        sa, sb, rs;
    logic [7:0]  ea, eb, re;
    logic [27:0] ma, mb, sum;
    logic        a_zero, b_zero;
    logic [7:0]  diff;

    always_comb begin
        diff     = (ea > eb) ? (ea - eb) : (eb - ea);
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtrahend sign is flipped at capture so the datapath only adds.
                        sa     <= src0[31];
                        ea     <= src0[30:23];
                        ma     <= {4'b0001, src0[22:0]};
                        sb     <= ~src1[31];
                        eb     <= src1[30:23];
                        mb     <= {4'b0001, src1[22:0]};
                        a_zero <= (src0[30:0] == '0);
                        b_zero <= (src1[30:0] == '0);
                        state  <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (a_zero) begin
                        out       <= {sb, eb, mb[22:0]};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (b_zero) begin
                        out       <= {sa, ea, ma[22:0]};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (ea == eb) begin
                        state <= OPER;
                    end else if (diff >= 8'd27) begin
                        if (ea > eb) begin
                            mb <= '0;
                            eb <= ea;
                        end else begin
                            ma <= '0;
                            ea <= eb;
                        end
                    end else if (ea > eb) begin
                        mb <= mb >> 1;
                        eb <= eb + 8'd1;
                    end else begin
                        ma <= ma >> 1;
                        ea <= ea + 8'd1;
                    end
                end
                OPER: begin
                    re <= ea;
                    if (sa == sb) begin
                        sum <= ma + mb;
                        rs  <= sa;
                    end else if (ma >= mb) begin
                        sum <= ma - mb;
                        rs  <= sa;
                    end else begin
                        sum <= mb - ma;
                        rs  <= sb;
                    end
                    state <= NORM;
                end
                NORM: begin
                    if (sum == '0) begin
                        out       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (sum[24]) begin
                        if (re >= 8'hFE)
                            out <= {rs, 8'hFF, 23'b0};
                        else
                            out <= {rs, re + 8'd1, sum[23:1]};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (sum[23]) begin
                        out       <= {rs, re, sum[22:0]};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (re <= 8'd1) begin
                        // Next left shift would drive the exponent to zero: flush.
                        out       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        sum <= sum << 1;
                        re  <= re - 8'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Scoreboard bench for fp_subtractor_seq: directed operand pairs with hand-computed results and latencies.
module tb_fp_subtractor_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src0, src1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        busy;

    fp_subtractor_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .src0(src0), .src1(src1), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] val;
        int          k;
        int          e0;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   seen     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: compares each result on its first valid cycle.
    always @(negedge clk) begin
        if (!rst && out_valid && !seen) begin
            exp_t e;
            seen = 1'b1;
            if (sb_q.size() == 0) begin
                check("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_value"}, out, e.val);
                if (e.k >= 0)
                    check({e.name, "_latency"}, cyc - e.e0, e.k);
            end
        end
        if (!out_valid) seen = 1'b0;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] val,
                         input int k, input string name, input bit push);
        exp_t e;
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_in_ready_timeout: in_ready=0, required 1", name);
        end
        src0     = a;
        src1     = b;
        in_valid = 1'b1;
        if (push) begin
            e.val = val; e.k = k; e.e0 = cyc + 1; e.name = name;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src0     = $urandom;
        src1     = $urandom;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: %0d results pending, required 0", name, sb_q.size());
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; src0 = '0; src1 = '0;
        repeat (2) @(negedge clk);
        check("reset_out", out, 32'h0);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;

        issue(32'h40400000, 32'h3F800000, 32'h40000000, 4,  "sub_3_1",      1); drain("sub_3_1");
        issue(32'h3F800000, 32'h3F400000, 32'h3E800000, 6,  "sub_1_075",    1); drain("sub_1_075");
        issue(32'h3F800000, 32'hBF800000, 32'h40000000, 3,  "carry",        1); drain("carry");
        issue(32'h3F800000, 32'h3F800000, 32'h00000000, 3,  "equal_zero",   1); drain("equal_zero");
        issue(32'h00000000, 32'h3F800000, 32'hBF800000, 1,  "a_zero",       1); drain("a_zero");
        issue(32'h40400000, 32'h00000000, 32'h40400000, 1,  "b_zero",       1); drain("b_zero");
        issue(32'h4F800000, 32'h3F800000, 32'h4F800000, 4,  "far_align",    1); drain("far_align");
        issue(32'h4B800000, 32'h3F800000, 32'h4B800000, 27, "trunc_align",  1); drain("trunc_align");
        issue(32'h7F000000, 32'hFF000000, 32'h7F800000, 3,  "overflow",     1); drain("overflow");
        issue(32'h00C00000, 32'h00800000, 32'h00000000, -1, "underflow",    1); drain("underflow");

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        issue(32'h40400000, 32'h3F800000, 32'h40000000, 4, "bp", 1);
        begin
            int t = 0;
            while (!out_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_hold", out, 32'h40000000);
            check("bp_valid_hold", {31'b0, out_valid}, 32'd1);
            check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", {31'b0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        issue(32'h3F800000, 32'h3F800000, 32'h00000000, 3, "bp_next", 1);
        check("bp_next_accepted", {31'b0, busy}, 32'd1);
        drain("bp_next");

        // Reset mid-operation discards the in-flight result.
        issue(32'h4B000000, 32'h3F800000, 32'h0, 0, "rst_op", 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        issue(32'h40400000, 32'h3F800000, 32'h40000000, 4, "post_rst", 1); drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
